// File: rtl/pbvi_pkg.sv
// Shared constants, types and FSM encoding for the PBVI backup engine stages.
package pbvi_pkg;
    localparam int NUM_BELIEF = 16;
    localparam int NUM_ACTION = 3;
    localparam int NUM_STATE  = 2;
    localparam int WORD_W     = 16;
    localparam int CNT_W      = $clog2(NUM_BELIEF);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [1:0]        action_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } step3_state_t;
endpackage

// File: rtl/pbvi_argmax3.sv
// Combinational 3-way unsigned maximum; ties resolve to the lowest action index.
module pbvi_argmax3
    import pbvi_pkg::*;
(
    input  word_t   d0,
    input  word_t   d1,
    input  word_t   d2,
    output action_t idx,
    output word_t   val
);
    always_comb begin
        idx = 2'd0;
        val = d0;
        if (!(val >= d1)) begin
            idx = 2'd1;
            val = d1;
        end
        if (!(val >= d2)) begin
            idx = 2'd2;
            val = d2;
        end
    end
endmodule

// File: rtl/pbvi_step3.sv
// PBVI step 3: per belief point, pick the action vector with the largest dot product.
// Optional STEP3_VALUE_OUT_EN adds value_out carrying the winning dot per point.
module pbvi_step3
    import pbvi_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  word_t   gamma_action_bilief [NUM_ACTION][NUM_BELIEF][NUM_STATE],
    input  word_t   point_belief [NUM_BELIEF][NUM_STATE],
    output logic    busy,
    output logic    done,
    output word_t   alpha_next [NUM_BELIEF][NUM_STATE],
    output action_t action_sel [NUM_BELIEF]
`ifdef STEP3_VALUE_OUT_EN
    ,
    output word_t   value_out [NUM_BELIEF]
`endif
);
    word_t        g_snap [NUM_ACTION][NUM_BELIEF][NUM_STATE];
    word_t        b_snap [NUM_BELIEF][NUM_STATE];
    step3_state_t state;
    cnt_t         cnt;
    word_t        d_p0 [NUM_ACTION];
    word_t        d_p1 [NUM_ACTION];
    cnt_t         idx_p1;
    logic         vld_p1;
    action_t      best_p2;
    word_t        best_val_p2;

    // Products and sum wrap modulo 2^WORD_W, matching the step 2 dot.
    function automatic word_t dot_trunc(input word_t g0, input word_t g1,
                                        input word_t b0, input word_t b1);
        logic [2*WORD_W-1:0] p0;
        logic [2*WORD_W-1:0] p1;
        p0 = g0 * b0;
        p1 = g1 * b1;
        return p0[WORD_W-1:0] + p1[WORD_W-1:0];
    endfunction

    // Stage 1: three dots for the point being issued
    always_comb begin
        for (int a = 0; a < NUM_ACTION; a++) begin
            d_p0[a] = dot_trunc(g_snap[a][cnt][0], g_snap[a][cnt][1],
                                b_snap[cnt][0], b_snap[cnt][1]);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            g_snap <= gamma_action_bilief;
            b_snap <= point_belief;
        end
        if (!en && state == ST_RUN) begin
            d_p1   <= d_p0;
            idx_p1 <= cnt;
        end
    end

    // Stage 2: argmax and write-back
    pbvi_argmax3 u_argmax (
        .d0  (d_p1[0]),
        .d1  (d_p1[1]),
        .d2  (d_p1[2]),
        .idx (best_p2),
        .val (best_val_p2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            vld_p1 <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < NUM_BELIEF; i++) begin
                action_sel[i] <= '0;
                for (int s = 0; s < NUM_STATE; s++) alpha_next[i][s] <= '0;
`ifdef STEP3_VALUE_OUT_EN
                value_out[i] <= '0;
`endif
            end
        end else begin
            done   <= 1'b0;
            vld_p1 <= 1'b0;
            if (en) begin
                // A start in any state (including mid-run) restarts from the fresh snapshot.
                state <= ST_RUN;
                cnt   <= '0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    ST_RUN: begin
                        vld_p1 <= 1'b1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == cnt_t'(NUM_BELIEF - 1)) state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
            if (vld_p1 && !en) begin
                action_sel[idx_p1] <= best_p2;
                for (int s = 0; s < NUM_STATE; s++) begin
                    alpha_next[idx_p1][s] <= g_snap[best_p2][idx_p1][s];
                end
`ifdef STEP3_VALUE_OUT_EN
                value_out[idx_p1] <= best_val_p2;
`endif
            end
        end
    end

`ifndef STEP3_VALUE_OUT_EN
    word_t unused_val;
    assign unused_val = best_val_p2;
`endif
endmodule

// File: tb/tb_pbvi_step3.sv
// Self-checking bench for pbvi_step3: reference model plus directed literal checks.
module tb_pbvi_step3;
    import pbvi_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b1;
    logic    en = 1'b0;
    word_t   g [NUM_ACTION][NUM_BELIEF][NUM_STATE];
    word_t   b [NUM_BELIEF][NUM_STATE];
    logic    busy, done;
    word_t   alpha_next [NUM_BELIEF][NUM_STATE];
    action_t action_sel [NUM_BELIEF];

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    bit chk_on = 1'b0;

    // Model state: results captured at the start edge, and cycles elapsed since it.
    bit    active = 1'b0;
    int    age = 0;
    int    m_sel [NUM_BELIEF];
    word_t m_alpha [NUM_BELIEF][NUM_STATE];

    always #5 clk = ~clk;

    pbvi_step3 dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .en                  (en),
        .gamma_action_bilief (g),
        .point_belief        (b),
        .busy                (busy),
        .done                (done),
        .alpha_next          (alpha_next),
        .action_sel          (action_sel)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int best_of(input int i);
        longint d [NUM_ACTION];
        int best = 0;
        for (int a = 0; a < NUM_ACTION; a++)
            d[a] = (longint'(g[a][i][0]) * b[i][0] + longint'(g[a][i][1]) * b[i][1]) % 65536;
        for (int a = 1; a < NUM_ACTION; a++)
            if (d[a] > d[best]) best = a;
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            age    <= 0;
        end else if (en) begin
            active <= 1'b1;
            age    <= 0;
            for (int i = 0; i < NUM_BELIEF; i++) begin
                m_sel[i] <= best_of(i);
                for (int s = 0; s < NUM_STATE; s++) m_alpha[i][s] <= g[best_of(i)][i][s];
            end
        end else if (active) begin
            age <= age + 1;
            if (age == 17) active <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("busy", busy, longint'(active && age < 17));
            check("done", done, longint'(active && age == 17));
            if (active && age == 17) begin
                for (int i = 0; i < NUM_BELIEF; i++) begin
                    check($sformatf("sel[%0d]", i), action_sel[i], m_sel[i]);
                    for (int s = 0; s < NUM_STATE; s++)
                        check($sformatf("alpha[%0d][%0d]", i, s), alpha_next[i][s], m_alpha[i][s]);
                end
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic set_all(input int g0 [NUM_ACTION], input int g1 [NUM_ACTION],
                           input int b0, input int b1);
        for (int i = 0; i < NUM_BELIEF; i++) begin
            b[i][0] = word_t'(b0);
            b[i][1] = word_t'(b1);
            for (int a = 0; a < NUM_ACTION; a++) begin
                g[a][i][0] = word_t'(g0[a]);
                g[a][i][1] = word_t'(g1[a]);
            end
        end
    endtask

    task automatic pat_variety();
        for (int i = 0; i < NUM_BELIEF; i++) begin
            b[i][0] = word_t'(i);
            b[i][1] = word_t'(15 - i);
            g[0][i][0] = 16'd16; g[0][i][1] = 16'd0;
            g[1][i][0] = 16'd0;  g[1][i][1] = 16'd16;
            g[2][i][0] = 16'd8;  g[2][i][1] = 16'd8;
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < NUM_BELIEF; i++)
            for (int s = 0; s < NUM_STATE; s++) begin
                b[i][s] = word_t'($urandom);
                for (int a = 0; a < NUM_ACTION; a++) g[a][i][s] = word_t'($urandom);
            end
    endtask

    task automatic fire();
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check(nm, cyc, 17);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int dc0;
        for (int i = 0; i < NUM_BELIEF; i++)
            for (int s = 0; s < NUM_STATE; s++) begin
                b[i][s] = '0;
                for (int a = 0; a < NUM_ACTION; a++) g[a][i][s] = '0;
            end
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel0", action_sel[0], 0);
        check("rst_alpha15", alpha_next[15][1], 0);

        // Basic select, inputs changed right after the start edge
        set_all('{1, 2, 3}, '{0, 0, 0}, 1, 0);
        fire();
        scramble();
        wait_done("basic_lat");
        check("basic_sel0", action_sel[0], 2);
        check("basic_alpha15_0", alpha_next[15][0], 3);
        check("basic_alpha15_1", alpha_next[15][1], 0);
        idle_cycles(2);

        // Tie on every action
        set_all('{5, 5, 5}, '{5, 5, 5}, 2, 3);
        fire();
        wait_done("tie_lat");
        check("tie_sel4", action_sel[4], 0);
        check("tie_alpha9_1", alpha_next[9][1], 5);
        idle_cycles(2);

        // Per-point variety, then a start in the done cycle
        pat_variety();
        fire();
        wait_done("var_lat");
        check("var_sel7", action_sel[7], 1);
        check("var_sel8", action_sel[8], 0);
        check("var_alpha7_1", alpha_next[7][1], 16);
        check("var_alpha8_0", alpha_next[8][0], 16);
        set_all('{256, 1, 0}, '{0, 0, 0}, 256, 0);
        fire();
        wait_done("trunc_lat");
        check("trunc_sel3", action_sel[3], 1);
        check("trunc_alpha3_0", alpha_next[3][0], 1);
        idle_cycles(2);

        // Restart at E5 with a second input set
        dc0 = done_cnt;
        pat_variety();
        fire();
        idle_cycles(4);
        set_all('{0, 0, 0}, '{10, 9, 8}, 0, 1);
        fire();
        scramble();
        wait_done("restart_lat");
        check("restart_sel0", action_sel[0], 0);
        check("restart_alpha15_1", alpha_next[15][1], 10);
        idle_cycles(3);
        check("restart_done_count", done_cnt - dc0, 1);

        // Reset at E8 of a run, then a clean run
        dc0 = done_cnt;
        set_all('{1, 2, 3}, '{0, 0, 0}, 1, 0);
        fire();
        idle_cycles(8);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sel2", action_sel[2], 0);
        check("midrst_alpha0_1", alpha_next[0][1], 0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(20);
        check("midrst_no_done", done_cnt - dc0, 0);
        set_all('{5, 5, 5}, '{5, 5, 5}, 2, 3);
        fire();
        wait_done("post_rst_lat");
        check("post_rst_alpha0_0", alpha_next[0][0], 5);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pbvi_step3.md
# pbvi_step3

Final stage of the PBVI backup. Consumes the per-action backed-up alpha vectors produced by step 2 (`gamma_action_bilief`) together with the belief point set. For every belief point it selects the action whose vector has the largest dot product with that point, and emits the selected vector as the new alpha vector for that point. It is a sequential, belief-serial engine: one belief point is issued per cycle through a 2-stage pipeline. It is started by step 2's `en_step3` pulse.

## Interface
- NUM_BELIEF, 16, number of belief points / output alpha vectors
- NUM_ACTION, 3, number of actions compared per point
- NUM_STATE, 2, states per vector
- WORD_W, 16, data word width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start pulse (driven by step 2 `en_step3`); sampled on clk
- gamma_action_bilief  in  WORD_W x [NUM_ACTION][NUM_BELIEF][NUM_STATE]  candidate vectors from step 2
- point_belief  in  WORD_W x [NUM_BELIEF][NUM_STATE]  belief points
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, all outputs final
- alpha_next  out  WORD_W x [NUM_BELIEF][NUM_STATE]  new alpha set
- action_sel  out  2 x [NUM_BELIEF]  chosen action per point

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on en=1, snapshot gamma_action_bilief and point_belief into internal registers; clear issue counter cnt; go to RUN.
- RUN: stage 1 computes three dots for point cnt, d[a] = g[a][cnt][0]*b[cnt][0] + g[a][cnt][1]*b[cnt][1]. It registers d[0..2] and cnt; then cnt++. When cnt==NUM_BELIEF-1 is issued, go to DRAIN.
- Stage 2 (every cycle its valid bit is set): argmax over d[0..2]. Compares use unsigned >=. Ties resolve to the lowest action index. It writes action_sel[idx]=best and alpha_next[idx][s]=snapshot g[best][idx][s].
- DRAIN: stage 2 retires the last point; go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Arithmetic: each product and the sum are truncated to the low WORD_W bits (modulo 2^16) before the compare. This matches step 2 dot semantics.
- en while busy: abort the run and restart from the fresh snapshot with cnt=0. Pipeline valid bits are cleared. Outputs already written keep their values until overwritten.
- en in DONE cycle: done still pulses; a new run starts (state RUN next).
- Inputs are ignored except at the en edge (snapshot). Step 2 may change its outputs during the run.

## Timing
- Reset values: busy=0, done=0, alpha_next all 0, action_sel all 0, FSM=IDLE, cnt=0, valid bits 0.
- Edge E0 samples en=1: snapshot taken, busy=1 after E0.
- Points 0..15 are issued on E1..E16 and written on E2..E17.
- done=1 after E17 for exactly one cycle. busy drops at the same edge.
- Latency from en edge to done is 17 cycles. Throughput is 1 point/cycle.
- alpha_next/action_sel are valid only from done onward. They are held until the next run overwrites them.
- Reset mid-run: immediate return to reset values. No done pulse.

## Configuration
- STEP3_VALUE_OUT_EN defined:
  - Adds output `value_out` (WORD_W x [NUM_BELIEF]), holding the winning truncated dot d[best] per point.
  - It is written in stage 2 alongside alpha_next and resets to 0.
- Undefined: the port and its registers are absent. All other behaviour is identical.

## Structure
- Shared package `pbvi_pkg`:
  - constants NUM_BELIEF, NUM_ACTION, NUM_STATE, WORD_W;
  - typedefs `word_t` (logic [WORD_W-1:0]) and `action_t` (logic [1:0]);
  - FSM enum `step3_state_t`.
- Sub-module `pbvi_argmax3`: combinational 3-way unsigned max with lowest-index tie-break. Outputs index and value. Used in stage 2.

## Test plan
- Basic select:
  - Stimulus: all b[i]={1,0}; g[a][i]={a+1,0}.
  - Required: done 17 cycles after en; every action_sel=2 and alpha_next[i]={3,0}.
- Tie:
  - Stimulus: all g[a][i]={5,5}, b[i]={2,3}.
  - Required: action_sel=0 for all i; alpha_next={5,5}.
- Per-point variety:
  - Stimulus: b[i]={i,15-i}; g[0]={16,0}, g[1]={0,16}, g[2]={8,8} for every i.
  - Required: action_sel=1 for i<=7 and 0 for i>=8 (a tie at 7.5 does not occur); alpha_next follows the selection.
- Truncation:
  - Stimulus: g[0][i]={0x0100,0}, g[1][i]={1,0}, g[2][i]={0,0}, b[i]={0x0100,0}.
  - Required: d0 wraps to 0, so d1 wins → action_sel=1, alpha_next={1,0}.
- Restart:
  - Stimulus: en, then en again at E5 with new inputs.
  - Required: exactly one done, 17 cycles after the second en, with results from the second input set only.
- Reset mid-run:
  - Stimulus: assert rst_n=0 at E8.
  - Required: all outputs 0 and busy=0 immediately, no done; a subsequent en completes normally.
